gpio_rr_arbiter: RTL and testbench

//   4-requester round-robin arbiter owning one shared 4:1 mux4-style select path.

---
 rtl/gpio_rr_arbiter_if.sv | 42 ++++
 rtl/gpio_rr_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_gpio_rr_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gpio_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpio_rr_arbiter_if
//   Bundles the request/grant handshake and the four master data words that
//   feed the shared bus port.
//   Signals:
//     req[3:0]     request per master (level, held until done)
//     done[3:0]    one-cycle completion pulse from the current owner
//     d0..d3       master data words (WIDTH bits each)
//     gnt[3:0]     one-hot grant, zero when idle
//     sel[1:0]     binary index of the owner (00 when idle)
//     busy         high while a grant is active
//     dout         selected master word, zero when idle
//     timeout      one-cycle pulse on a forced release
//   Modports:
//     master  requester side (drives req/done/data, observes grant outputs)
//     slave   arbiter side
// ---------------------------------------------------------------------------
interface gpio_rr_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       req;
    logic [3:0]       done;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             busy;
    logic [WIDTH-1:0] dout;
    logic             timeout;

    modport master (
        output req, done, d0, d1, d2, d3,
        input  gnt, sel, busy, dout, timeout
    );

    modport slave (
        input  req, done, d0, d1, d2, d3,
        output gnt, sel, busy, dout, timeout
    );
endinterface

// File: rtl/gpio_rr_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_rr_arbiter
//   Four-requester round-robin arbiter driving the select of a shared 4:1
//   data mux. One master owns the bus at a time; on release the pointer moves
//   past the owner and the next requester is handed the bus in the same edge.
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     bus      gpio_rr_arbiter_if.slave (req/done/d0..d3 in,
//              gnt/sel/busy/dout/timeout out)
//   Parameters:
//     WIDTH     data word width
//     MAX_HOLD  longest grant in cycles before forced release (>= 2)
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : hold counter force-releases an owner after MAX_HOLD cycles
//                 and pulses timeout
//     undefined : no counter, timeout tied low, grants held indefinitely
// ---------------------------------------------------------------------------
//   state | meaning
//   IDLE  | no owner, gnt=0, scanning req from ptr
//   GRANT | owner holds the bus, waiting for done/req drop (or timeout)
// ---------------------------------------------------------------------------
module gpio_rr_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    gpio_rr_arbiter_if.slave bus
);

    if (MAX_HOLD < 2) begin : g_hold_check
        $error("gpio_rr_arbiter: MAX_HOLD must be >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] owner;
    logic [1:0] owner_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic       rel_cond;
    logic       forced;
    logic       release_now;
    logic [3:0] cand_req;
    logic [1:0] scan_start;
    logic [2:0] pick_res;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_nxt;
    logic          timeout_q;
    logic          timeout_nxt;
    logic          new_grant;
`endif

    // First set bit of r scanning start, start+1, ... (mod 4).
    // Result is {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] k;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = start + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        rel_cond = (state == GRANT) && (bus.done[owner] || !bus.req[owner]);
`ifdef ARB_TIMEOUT_EN
        // A genuine release in the same cycle wins, so no timeout pulse then.
        forced = (state == GRANT) && !rel_cond && (hold_cnt == HOLD_LAST);
`else
        forced = 1'b0;
`endif
        release_now = rel_cond || forced;

        // On release the old owner is masked so it cannot be regranted in
        // the same edge, even if its req is still high.
        if (state == GRANT) begin
            cand_req   = bus.req & ~(4'b0001 << owner);
            scan_start = owner + 2'd1;
        end else begin
            cand_req   = bus.req;
            scan_start = ptr;
        end
        pick_res = pick(cand_req, scan_start);

        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;

        case (state)
            IDLE: begin
                if (pick_res[2]) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_res[1:0];
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_nxt = owner + 2'd1;
                    if (pick_res[2]) begin
                        owner_nxt = pick_res[1:0];
                    end else begin
                        state_nxt = IDLE;
                        owner_nxt = 2'd0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = 2'd0;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        timeout_nxt = forced;
        new_grant   = (state_nxt == GRANT) && ((state == IDLE) || release_now);
        if (new_grant) begin
            hold_cnt_nxt = '0;
        end else if ((state == GRANT) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
        end else begin
            hold_cnt_nxt = hold_cnt;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Outputs: gnt/sel/busy decode registers only; dout is the unregistered
    // data mux.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.busy = (state == GRANT);
        bus.sel  = owner;
        bus.gnt  = (state == GRANT) ? (4'b0001 << owner) : 4'b0000;
`ifdef ARB_TIMEOUT_EN
        bus.timeout = timeout_q;
`else
        bus.timeout = 1'b0;
`endif
        bus.dout = '0;
        if (state == GRANT) begin
            case (owner)
                2'd0:    bus.dout = bus.d0;
                2'd1:    bus.dout = bus.d1;
                2'd2:    bus.dout = bus.d2;
                default: bus.dout = bus.d3;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpio_rr_arbiter
//   Directed bench for gpio_rr_arbiter: reset, single grant, rotation,
//   fairness masking, abandon, and hold/timeout behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpio_rr_arbiter;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gpio_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    gpio_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] rot_done [5];
    logic [3:0] rot_gnt  [5];
    logic [1:0] rot_sel  [5];

    initial begin
        total = 0;
        bad   = 0;
        rot_done = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_gnt  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rot_sel  = '{2'd1,    2'd2,    2'd3,    2'd0,    2'd1};

        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        bus.d0   = 32'hA5A5_0000;
        bus.d1   = 32'hA5A5_0001;
        bus.d2   = 32'hA5A5_0002;
        bus.d3   = 32'hA5A5_0003;
        repeat (2) step();

        chk("rst_gnt",     32'(bus.gnt),     32'h0);
        chk("rst_sel",     32'(bus.sel),     32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_timeout", 32'(bus.timeout), 32'h0);
        chk("rst_dout",    bus.dout,         32'h0);
        rst_n = 1'b1;

        // 1: reset mid-grant drops gnt before the next edge
        bus.req = 4'b0001;
        step();
        chk("t1_gnt",  32'(bus.gnt), 32'h1);
        chk("t1_dout", bus.dout,     32'hA5A5_0000);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_rst_gnt",     32'(bus.gnt),     32'h0);
        chk("t1_rst_busy",    32'(bus.busy),    32'h0);
        chk("t1_rst_dout",    bus.dout,         32'h0);
        chk("t1_rst_timeout", 32'(bus.timeout), 32'h0);
        bus.req = 4'b1111;
        #1 rst_n = 1'b1;
        step();
        chk("t3_first_gnt", 32'(bus.gnt), 32'h1);

        // 3: rotation with all requesting, no idle cycles
        for (int i = 0; i < 5; i++) begin
            bus.done = rot_done[i];
            step();
            bus.done = 4'b0000;
            chk($sformatf("t3_gnt_%0d", i),  32'(bus.gnt),  32'(rot_gnt[i]));
            chk($sformatf("t3_sel_%0d", i),  32'(bus.sel),  32'(rot_sel[i]));
            chk($sformatf("t3_busy_%0d", i), 32'(bus.busy), 32'h1);
        end

        // 4: fairness - owner 1 done while req still high
        bus.req  = 4'b0011;
        bus.done = 4'b0010;
        step();
        bus.done = 4'b0000;
        chk("t4_gnt", 32'(bus.gnt), 32'h1);
        chk("t4_sel", 32'(bus.sel), 32'h0);
        bus.done = 4'b0001;
        step();
        bus.done = 4'b0000;
        chk("t4_mask0_gnt", 32'(bus.gnt), 32'h2);
        // sole requester released is masked for one edge, regranted next
        bus.req  = 4'b0010;
        bus.done = 4'b0010;
        step();
        bus.done = 4'b0000;
        chk("t4_bubble_gnt",  32'(bus.gnt),  32'h0);
        chk("t4_bubble_busy", 32'(bus.busy), 32'h0);
        step();
        chk("t4_regrant_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        step();
        chk("t4_drop_gnt", 32'(bus.gnt), 32'h0);

        // 2: single request on master 2
        bus.req = 4'b0100;
        step();
        chk("t2_gnt",  32'(bus.gnt), 32'h4);
        chk("t2_sel",  32'(bus.sel), 32'h2);
        chk("t2_dout", bus.dout,     32'hA5A5_0002);
        bus.d2 = 32'h1234_5678;
        #1;
        chk("t2_dout_comb", bus.dout, 32'h1234_5678);
        bus.d2   = 32'hA5A5_0002;
        bus.done = 4'b0100;
        bus.req  = 4'b0000;
        step();
        bus.done = 4'b0000;
        chk("t2_rel_gnt",  32'(bus.gnt),  32'h0);
        chk("t2_rel_dout", bus.dout,      32'h0);
        chk("t2_rel_busy", 32'(bus.busy), 32'h0);
        chk("t2_rel_sel",  32'(bus.sel),  32'h0);

        // 5: abandon by owner 3; non-owner done ignored
        bus.req = 4'b1000;
        step();
        chk("t5_gnt",  32'(bus.gnt), 32'h8);
        chk("t5_sel",  32'(bus.sel), 32'h3);
        chk("t5_dout", bus.dout,     32'hA5A5_0003);
        bus.done = 4'b0001;
        step();
        bus.done = 4'b0000;
        chk("t5_foreign_done_gnt", 32'(bus.gnt), 32'h8);
        bus.req = 4'b0000;
        step();
        chk("t5_abandon_gnt",  32'(bus.gnt),  32'h0);
        chk("t5_abandon_busy", 32'(bus.busy), 32'h0);
        bus.req = 4'b1111;
        step();
        chk("t5_ptr0_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        step();
        chk("t5_idle_gnt", 32'(bus.gnt), 32'h0);

        // 6: hold limit
        bus.req = 4'b0010;
        step();
        chk("t6_gnt_c1", 32'(bus.gnt), 32'h2);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("t6_gnt_c%0d", c), 32'(bus.gnt),     32'h2);
            chk($sformatf("t6_to_c%0d", c),  32'(bus.timeout), 32'h0);
        end
        bus.req = 4'b0110;
        step();
        chk("t6_timeout_pulse", 32'(bus.timeout), 32'h1);
        chk("t6_handoff_gnt",   32'(bus.gnt),     32'h4);
        step();
        chk("t6_timeout_clear", 32'(bus.timeout), 32'h0);
        chk("t6_after_gnt",     32'(bus.gnt),     32'h4);
        bus.req  = 4'b0000;
        bus.done = 4'b0100;
        step();
        bus.done = 4'b0000;
        chk("t6_end_gnt", 32'(bus.gnt), 32'h0);
`else
        for (int c = 0; c < 100; c++) begin
            step();
            chk($sformatf("t6_hold_gnt_%0d", c), 32'(bus.gnt),     32'h2);
            chk($sformatf("t6_hold_to_%0d", c),  32'(bus.timeout), 32'h0);
        end
        bus.req = 4'b0000;
        step();
        chk("t6_end_gnt", 32'(bus.gnt), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
